// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the unified memory port arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - REQ_IF/REQ_D: requester identifiers (fetch = 0, load/store = 1)
//   - LAT_W       : latency counter width, enough for MEM_LAT up to 7
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int LAT_W = 3;

endpackage

// File: rtl/arb_lat_ctr.sv
// arb_lat_ctr
//   Loadable down-counter that tracks the memory read latency.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (count -> 0)
//     load      : load load_val (takes priority over dec)
//     load_val  : value to load
//     dec       : decrement by one, saturating at zero
//     last      : count is exactly 1 (final latency cycle)
module arb_lat_ctr
    import mem_arb_pkg::*;
#(
    parameter int W = LAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   requester (if_*) and the load/store requester (d_*). One access is in
//   flight at a time; reads wait MEM_LAT cycles for mem_rdata.
//
//   Handshake: a requester raises req with addr (and we/wdata for the data
//   port) and holds all of them stable until it sees its one-cycle gnt
//   pulse. gnt coincides with the memory access (mem_en). For reads the
//   matching rvalid pulses MEM_LAT cycles after gnt; rdata is a direct
//   copy of mem_rdata and means something only while rvalid is high.
//
//   Ports:
//     Clk, Rst                      clock, synchronous active-high reset
//     if_req/if_addr                fetch request (always a read)
//     if_gnt/if_rvalid/if_rdata     fetch grant and returned data
//     d_req/d_we/d_addr/d_wdata     load/store request
//     d_gnt/d_rvalid/d_rdata        data grant and returned load data
//     mem_en/mem_we/mem_addr/       memory macro interface
//     mem_wdata/mem_rdata
//     busy                          access in flight (ISSUE or WAIT)
//
//   Build option: define ARB_ROUND_ROBIN_EN to alternate the winner on
//   simultaneous requests; otherwise the data port always wins a tie.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

    arb_state_t state;
    logic       winner;
    logic       pick_d;
    logic       lat_load;
    logic       lat_dec;
    logic       lat_last;
    logic       read_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_win;
`endif

    // Tie-break: data wins by default; with round robin the requester that
    // did not take the previous grant wins.
    always_comb begin
        pick_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && if_req) begin
            pick_d = (last_win == REQ_IF);
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            winner    <= REQ_IF;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_win  <= REQ_IF;
`endif
        end else begin
            // gnt/mem_en/mem_we are one-cycle pulses aligned with ISSUE
            if_gnt <= 1'b0;
            d_gnt  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state  <= ISSUE;
                        mem_en <= 1'b1;
                        winner <= pick_d ? REQ_D : REQ_IF;
`ifdef ARB_ROUND_ROBIN_EN
                        last_win <= pick_d ? REQ_D : REQ_IF;
`endif
                        if (pick_d) begin
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            if_gnt   <= 1'b1;
                            mem_addr <= if_addr;
                        end
                    end
                end
                ISSUE: begin
                    // mem_we still holds the latched write enable here
                    state <= mem_we ? IDLE : WAIT;
                end
                WAIT: begin
                    if (lat_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign lat_load = (state == ISSUE) && !mem_we;
    assign lat_dec  = (state == WAIT);

    arb_lat_ctr #(
        .W (LAT_W)
    ) u_lat_ctr (
        .clk      (Clk),
        .rst      (Rst),
        .load     (lat_load),
        .load_val (LAT_LOAD),
        .dec      (lat_dec),
        .last     (lat_last)
    );

    // Decoded only from registered state: no path from req inputs.
    assign read_done = (state == WAIT) && lat_last;
    assign if_rvalid = read_done && (winner == REQ_IF);
    assign d_rvalid  = read_done && (winner == REQ_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-ported unified instruction/data memory between two requesters: the instruction-fetch stage and the load/store stage.
- Sits between the CPU datapath and the memory macro.
- Arbitrates between the two requesters, sequences one access at a time, and tracks the memory's fixed read latency.
- Returns read data to the winning requester; the requester holds its stage stalled until its access completes.

## Interface
Parameters:
- ADDR_W, 12, memory word-address width
- DATA_W, 16, memory/instruction word width
- MEM_LAT, 1, memory read latency in cycles (mem_en cycle to valid mem_rdata); legal range 1..7

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rvalid  out  1  one-cycle fetch data valid
- if_rdata  out  DATA_W  fetch data, meaningful only with if_rvalid
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle grant pulse to data port
- d_rvalid  out  1  one-cycle load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  access in flight (state ≠ IDLE)

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Samples the requests; if any is high, latches the winner, its address, write-enable and write data.
  - Moves to ISSUE.
- ISSUE (exactly one cycle):
  - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata = latched values.
  - The winner's gnt pulses high.
  - On a write: next state IDLE.
  - On a read: loads the latency counter with MEM_LAT; next state WAIT.
- WAIT:
  - Decrements the counter each cycle.
  - In the cycle the counter reaches 1, the winner's rvalid = 1 and its rdata = mem_rdata (passthrough); next state IDLE.
- Priority: fixed; d_req wins over if_req on a simultaneous request, so an in-flight load/store is never starved by fetch.
- Fetch is always a read: no fetch write path.
- Non-winning request stays pending and is evaluated again in the next IDLE cycle.
- Requester must keep req, addr, we and wdata stable until its gnt. Dropping req before gnt is illegal; the arbiter does not check it.
- if_rdata/d_rdata: both are driven from mem_rdata at all times; only rvalid qualifies them.
- Reset, including mid-access:
  - state = IDLE, counter = 0, latched winner cleared.
  - All outputs 0: gnt, rvalid, mem_en, mem_we, busy, mem_addr, mem_wdata.
  - In-flight read data is discarded with no rvalid; requesters re-request after reset.

## Timing
- Read, req sampled in IDLE at cycle N:
  - gnt and mem_en at N+1.
  - rvalid at N+1+MEM_LAT.
  - Earliest next issue at N+3+MEM_LAT.
- Write, req sampled at N: gnt and mem_en at N+1; earliest next issue at N+3.
- Back-to-back loads with MEM_LAT=1: one access every 3 cycles.
- busy: high in ISSUE and WAIT, low in IDLE.
- No combinational path from any req input to any output.

## Configuration
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - On a simultaneous request, the requester that did not win the previous grant wins.
  - Last-winner flag resets to "fetch", so data wins the first tie after reset.
- Undefined: fixed data-over-fetch priority as above; no last-winner flag is synthesized.

## Structure
- Shared package mem_arb_pkg:
  - State enum (IDLE, ISSUE, WAIT).
  - Requester ID constants REQ_IF = 0, REQ_D = 1.
  - Latency counter width, 3 bits, sized for MEM_LAT ≤ 7.
- One sub-module: arb_lat_ctr, a loadable down-counter with a "last" flag, instanced once.
- Arbitration and FSM stay in mem_port_arbiter.

## Test plan
- Single fetch, MEM_LAT=1, if_addr=0x010, mem returns 0xA5C3: if_gnt and mem_en at N+1, if_rvalid with if_rdata=0xA5C3 at N+2, busy low at N+3.
- Simultaneous if_req and d_req (load 0x200), macro off: d_gnt first; if_gnt at the next ISSUE three cycles later; repeat the tie twice, data wins both times.
- Same tie with ARB_ROUND_ROBIN_EN: data wins the first tie, fetch the second, data the third.
- Store d_addr=0x0FF, d_wdata=0x1234: mem_we=1 with matching addr/data for exactly one cycle; no d_rvalid; a pending fetch issues 2 cycles after the store's ISSUE.
- MEM_LAT=4, load: d_rvalid exactly 4 cycles after mem_en; a fetch request raised during WAIT gets no grant until after d_rvalid.
- Assert Rst during WAIT of a read: next cycle all outputs 0, no rvalid ever emitted for that read; after reset, a re-issued request completes normally.
